mc_ctrl_unit: RTL and testbench
===============================

// Module: mc_ctrl_unit
// PURPOSE
//  Multi-cycle MIPS control FSM. Decodes opcode/funct and sequences IF/ID/EX/MEM/WB.
//  Drives datapath select lines; reg_dst[1:0] is the select of the 5-bit 4:1 write-address mux.
//  Sits upstream of that mux and of the PC, memory, ALU and register-file muxes.
// PARAMETERS
//  STATE_W  4  state register width (13 states used)
//  MEM_WAIT 1  1: IF/MEM_RD/MEM_WR hold until mem_ready; 0: ignore mem_ready
// PORTS
//  clk          in   1  rising-edge clock
//  rst          in   1  synchronous reset, active-low
//  opcode       in   6  IR[31:26]
//  funct        in   6  IR[5:0]
//  zero         in   1  ALU zero flag
//  mem_ready    in   1  memory transfer complete this cycle
//  pc_write     out  1  unconditional PC load
//  pc_write_cond out 1  conditional PC load; taken = zero ^ bne
//  bne          out  1  invert branch condition
//  i_or_d       out  1  0: PC address, 1: ALUOut address
//  mem_read     out  1  memory read request
//  mem_write    out  1  memory write request
//  ir_write     out  1  load IR
//  reg_dst      out  2  00 rt, 01 rd, 10 $31, 11 unused (0)
//  mem_to_reg   out  2  00 ALUOut, 01 MDR, 10 PC
//  reg_write    out  1  register-file write enable
//  alu_src_a    out  1  0: PC, 1: A
//  alu_src_b    out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  pc_source    out  2  00 ALU result, 01 ALUOut, 10 jump target
//  alu_ctrl     out  3  000 and, 001 or, 010 add, 110 sub, 111 slt, 100 nor
//  illegal_op   out  1  one-cycle pulse in ID on undecoded opcode/funct
//  state        out  4  current state, debug
// BEHAVIOUR
//  Moore outputs decoded from state; rst==0 at an edge -> state=IF; while rst==0, all outputs 0.
//  States: IF0 ID1 MA2 MRD3 MWB4 MWR5 REX6 RWB7 BR8 J9 IEX10 IWB11 JAL12.
//  IF: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=add.
//    ir_write and pc_write asserted only when mem_ready (MEM_WAIT=1); else stay in IF.
//  ID: alu_src_a=0, alu_src_b=11, alu_ctrl=add (branch target precompute). Dispatch:
//    R(000000)->REX; lw(100011)/sw(101011)->MA; beq(000100)/bne(000101)->BR;
//    j(000010)->J; addi/andi/ori/slti(001000/001100/001101/001010)->IEX; jal(000011) see CONFIG;
//    else illegal_op=1, ->IF.
//  MA->MRD (lw) or MWR (sw). MRD/MWR: i_or_d=1, hold until mem_ready; MRD->MWB, MWR->IF.
//  MWB: reg_dst=00, mem_to_reg=01, reg_write=1. REX: alu_src_a=1, alu_src_b=00, alu_ctrl=alu_dec(funct).
//  RWB: reg_dst=01, mem_to_reg=00, reg_write=1. IEX: alu_src_b=10, op-specific alu_ctrl; IWB: reg_dst=00.
//  BR: alu_src_a=1, alu_src_b=00, sub, pc_write_cond=1, pc_source=01, bne=(opcode==bne).
//  J: pc_write=1, pc_source=10. All WB/BR/J/JAL states ->IF.
//  Undecoded funct in R-type: illegal_op in ID, no REX.
//  Latency at mem_ready=1: R/I-ALU 4, lw 5, sw 4, beq/bne 3, j 3, jal 3 cycles.
//  mem_ready ignored outside IF/MRD/MWR. Reset mid-instruction: abort, no write, IF next.
// CONFIGURATION
//  MC_CTRL_JAL_EN defined: jal -> JAL: reg_dst=10, mem_to_reg=10, reg_write=1,
//    pc_write=1, pc_source=10. Undefined: jal is illegal (illegal_op pulse, ->IF).
// STRUCTURE
//  mc_ctrl_pkg: state codes, opcode/funct constants, alu_ctrl, reg_dst, mem_to_reg codes.
//  Sub-module alu_dec: funct -> alu_ctrl (add/sub/and/or/slt/nor) plus valid flag.
// TESTING
//  rst=0 two cycles, release -> state=IF, mem_read=1, all writes 0 until IF.
//  add (op 0, funct 100000), mem_ready=1 -> IF,ID,REX,RWB; RWB reg_dst=01, reg_write=1.
//  lw, mem_ready low 3 cycles in MRD -> MRD held 4 cycles, then MWB reg_dst=00, mem_to_reg=01.
//  beq zero=1 / bne zero=1 -> BR with pc_write_cond=1, bne=0 / bne=1, back to IF after 3 cycles.
//  jal with MC_CTRL_JAL_EN -> JAL reg_dst=10, mem_to_reg=10; without -> illegal_op pulse in ID.
//  rst=0 asserted in MWR -> no further mem_write, state=IF next cycle.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: state codes, opcodes, ALU and mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF  = 4'd0,
    S_ID  = 4'd1,
    S_MA  = 4'd2,
    S_MRD = 4'd3,
    S_MWB = 4'd4,
    S_MWR = 4'd5,
    S_REX = 4'd6,
    S_RWB = 4'd7,
    S_BR  = 4'd8,
    S_J   = 4'd9,
    S_IEX = 4'd10,
    S_IWB = 4'd11,
    S_JAL = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_NOR = 3'b100;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  function automatic logic [2:0] imm_alu_ctrl(input logic [5:0] op);
    case (op)
      OP_ANDI: imm_alu_ctrl = ALU_AND;
      OP_ORI:  imm_alu_ctrl = ALU_OR;
      OP_SLTI: imm_alu_ctrl = ALU_SLT;
      default: imm_alu_ctrl = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Instruction-field inputs and datapath control outputs of the multi-cycle controller.
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       bne;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic [2:0] alu_ctrl;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    output opcode, funct, zero, mem_ready,
    input  pc_write, pc_write_cond, bne, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
           alu_ctrl, illegal_op, state
  );

  modport slave (
    input  opcode, funct, zero, mem_ready,
    output pc_write, pc_write_cond, bne, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
           alu_ctrl, illegal_op, state
  );
endinterface

// File: rtl/alu_dec.sv
// R-type funct decoder: maps funct to the ALU operation and flags unsupported codes.
module alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o,
  output logic       valid_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    valid_o    = 1'b1;
    case (funct_i)
      FN_ADD:  alu_ctrl_o = ALU_ADD;
      FN_SUB:  alu_ctrl_o = ALU_SUB;
      FN_AND:  alu_ctrl_o = ALU_AND;
      FN_OR:   alu_ctrl_o = ALU_OR;
      FN_SLT:  alu_ctrl_o = ALU_SLT;
      FN_NOR:  alu_ctrl_o = ALU_NOR;
      default: valid_o    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle MIPS control FSM sequencing IF/ID/EX/MEM/WB; jal support under MC_CTRL_JAL_EN.
//  state | meaning
//  IF    | fetch, PC+4 ; ID  | decode, branch target ; MA | address calc
//  MRD   | load read   ; MWB | load writeback        ; MWR | store write
//  REX   | R-type exec ; RWB | R-type writeback      ; BR  | beq/bne
//  J     | jump        ; IEX | imm exec ; IWB | imm writeback ; JAL | jump-and-link
module mc_ctrl_unit
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W  = 4,
  parameter bit MEM_WAIT = 1'b1
) (
  input logic       clk,
  input logic       rst,
  mc_ctrl_if.slave  bus
);

  state_e     state_q, state_d;
  state_e     id_next;
  logic [2:0] rdec_ctrl;
  logic       rdec_valid;
  logic       mem_go;

  alu_dec u_alu_dec (
    .funct_i   (bus.funct),
    .alu_ctrl_o(rdec_ctrl),
    .valid_o   (rdec_valid)
  );

  assign mem_go = !MEM_WAIT || bus.mem_ready;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IF;
    else      state_q <= state_d;
  end

  // Dispatch target out of ID; S_IF here means the instruction was not recognised.
  always_comb begin
    id_next = S_IF;
    case (bus.opcode)
      OP_RTYPE:                         id_next = rdec_valid ? S_REX : S_IF;
      OP_LW, OP_SW:                     id_next = S_MA;
      OP_BEQ, OP_BNE:                   id_next = S_BR;
      OP_J:                             id_next = S_J;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: id_next = S_IEX;
`ifdef MC_CTRL_JAL_EN
      OP_JAL:                           id_next = S_JAL;
`endif
      default:                          id_next = S_IF;
    endcase
  end

  always_comb begin
    state_d           = state_q;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.bne           = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_dst       = RD_RT;
    bus.mem_to_reg    = M2R_ALU;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.pc_source     = 2'b00;
    bus.alu_ctrl      = ALU_AND;
    bus.illegal_op    = 1'b0;
    bus.state         = '0;
    // Every output is held low while reset is asserted, including the debug state.
    if (rst) begin
      bus.state = STATE_W'(state_q);
      case (state_q)
        S_IF: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.alu_ctrl  = ALU_ADD;
          if (mem_go) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            state_d      = S_ID;
          end
        end
        S_ID: begin
          bus.alu_src_b  = 2'b11;
          bus.alu_ctrl   = ALU_ADD;
          bus.illegal_op = (id_next == S_IF);
          state_d        = id_next;
        end
        S_MA: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          bus.alu_ctrl  = ALU_ADD;
          state_d       = (bus.opcode == OP_LW) ? S_MRD : S_MWR;
        end
        S_MRD: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
          if (mem_go) state_d = S_MWB;
        end
        S_MWB: begin
          bus.reg_dst    = RD_RT;
          bus.mem_to_reg = M2R_MDR;
          bus.reg_write  = 1'b1;
          state_d        = S_IF;
        end
        S_MWR: begin
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
          if (mem_go) state_d = S_IF;
        end
        S_REX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_ctrl  = rdec_ctrl;
          state_d       = S_RWB;
        end
        S_RWB: begin
          bus.reg_dst   = RD_RD;
          bus.reg_write = 1'b1;
          state_d       = S_IF;
        end
        S_BR: begin
          bus.alu_src_a     = 1'b1;
          bus.alu_ctrl      = ALU_SUB;
          bus.pc_write_cond = 1'b1;
          bus.pc_source     = 2'b01;
          bus.bne           = (bus.opcode == OP_BNE);
          state_d           = S_IF;
        end
        S_J: begin
          bus.pc_write  = 1'b1;
          bus.pc_source = 2'b10;
          state_d       = S_IF;
        end
        S_IEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          bus.alu_ctrl  = imm_alu_ctrl(bus.opcode);
          state_d       = S_IWB;
        end
        S_IWB: begin
          bus.reg_dst   = RD_RT;
          bus.reg_write = 1'b1;
          state_d       = S_IF;
        end
        S_JAL: begin
          bus.reg_dst    = RD_RA;
          bus.mem_to_reg = M2R_PC;
          bus.reg_write  = 1'b1;
          bus.pc_write   = 1'b1;
          bus.pc_source  = 2'b10;
          state_d        = S_IF;
        end
        default: state_d = S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Directed bench for mc_ctrl_unit: reset, R/I/lw/sw/branch/jump sequencing, illegal decode, jal.
module tb_mc_ctrl_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mrd_cnt;

  mc_ctrl_if bus ();

  mc_ctrl_unit #(.STATE_W(4), .MEM_WAIT(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    bus.opcode = 6'd0;
    bus.funct = 6'd0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_pc_write", 32'(bus.pc_write), 32'd0);
    chk("rst_alu_src_b", 32'(bus.alu_src_b), 32'd0);

    rst = 1'b1;
    #1;
    chk("if_state", 32'(bus.state), 32'd0);
    chk("if_mem_read", 32'(bus.mem_read), 32'd1);
    chk("if_ir_write_wait", 32'(bus.ir_write), 32'd0);
    chk("if_alu_src_b", 32'(bus.alu_src_b), 32'd1);
    chk("if_alu_ctrl", 32'(bus.alu_ctrl), 32'd2);
    cyc();
    chk("if_hold", 32'(bus.state), 32'd0);

    // add
    bus.funct = 6'b100000;
    bus.mem_ready = 1'b1;
    #1;
    chk("if_ir_write", 32'(bus.ir_write), 32'd1);
    chk("if_pc_write", 32'(bus.pc_write), 32'd1);
    cyc();
    chk("add_id", 32'(bus.state), 32'd1);
    chk("id_alu_src_b", 32'(bus.alu_src_b), 32'd3);
    chk("id_illegal", 32'(bus.illegal_op), 32'd0);
    cyc();
    chk("add_rex", 32'(bus.state), 32'd6);
    chk("rex_src_a", 32'(bus.alu_src_a), 32'd1);
    chk("rex_alu_add", 32'(bus.alu_ctrl), 32'd2);
    cyc();
    chk("add_rwb", 32'(bus.state), 32'd7);
    chk("rwb_reg_dst", 32'(bus.reg_dst), 32'd1);
    chk("rwb_reg_write", 32'(bus.reg_write), 32'd1);
    chk("rwb_mem_to_reg", 32'(bus.mem_to_reg), 32'd0);
    cyc();
    chk("add_done", 32'(bus.state), 32'd0);

    // sub and nor through the funct decoder
    bus.funct = 6'b100010;
    cyc();
    cyc();
    chk("rex_alu_sub", 32'(bus.alu_ctrl), 32'd6);
    cyc();
    cyc();
    bus.funct = 6'b100111;
    cyc();
    cyc();
    chk("rex_alu_nor", 32'(bus.alu_ctrl), 32'd4);
    cyc();
    cyc();

    // lw with three wait cycles in MRD
    bus.opcode = 6'b100011;
    cyc();
    cyc();
    chk("lw_ma", 32'(bus.state), 32'd2);
    chk("ma_src_b", 32'(bus.alu_src_b), 32'd2);
    bus.mem_ready = 1'b0;
    cyc();
    chk("lw_mrd", 32'(bus.state), 32'd3);
    chk("mrd_i_or_d", 32'(bus.i_or_d), 32'd1);
    chk("mrd_mem_read", 32'(bus.mem_read), 32'd1);
    mrd_cnt = 1;
    for (int k = 0; k < 10; k++) begin
      if (mrd_cnt == 4) bus.mem_ready = 1'b1;
      cyc();
      if (bus.state != 4'd3) break;
      mrd_cnt++;
    end
    chk("mrd_cycles", 32'(mrd_cnt), 32'd4);
    chk("lw_mwb", 32'(bus.state), 32'd4);
    chk("mwb_reg_dst", 32'(bus.reg_dst), 32'd0);
    chk("mwb_mem_to_reg", 32'(bus.mem_to_reg), 32'd1);
    chk("mwb_reg_write", 32'(bus.reg_write), 32'd1);
    cyc();
    chk("lw_done", 32'(bus.state), 32'd0);

    // beq
    bus.opcode = 6'b000100;
    bus.zero = 1'b1;
    cyc();
    cyc();
    chk("beq_br", 32'(bus.state), 32'd8);
    chk("beq_cond", 32'(bus.pc_write_cond), 32'd1);
    chk("beq_bne", 32'(bus.bne), 32'd0);
    chk("beq_pc_src", 32'(bus.pc_source), 32'd1);
    chk("beq_alu", 32'(bus.alu_ctrl), 32'd6);
    cyc();
    chk("beq_done", 32'(bus.state), 32'd0);

    // bne
    bus.opcode = 6'b000101;
    cyc();
    cyc();
    chk("bne_br", 32'(bus.state), 32'd8);
    chk("bne_cond", 32'(bus.pc_write_cond), 32'd1);
    chk("bne_bne", 32'(bus.bne), 32'd1);
    cyc();
    chk("bne_done", 32'(bus.state), 32'd0);

    // ori
    bus.opcode = 6'b001101;
    cyc();
    cyc();
    chk("ori_iex", 32'(bus.state), 32'd10);
    chk("ori_alu", 32'(bus.alu_ctrl), 32'd1);
    chk("iex_src_b", 32'(bus.alu_src_b), 32'd2);
    cyc();
    chk("ori_iwb", 32'(bus.state), 32'd11);
    chk("iwb_reg_write", 32'(bus.reg_write), 32'd1);
    chk("iwb_reg_dst", 32'(bus.reg_dst), 32'd0);
    cyc();
    chk("ori_done", 32'(bus.state), 32'd0);

    // j
    bus.opcode = 6'b000010;
    cyc();
    cyc();
    chk("j_state", 32'(bus.state), 32'd9);
    chk("j_pc_write", 32'(bus.pc_write), 32'd1);
    chk("j_pc_src", 32'(bus.pc_source), 32'd2);
    cyc();
    chk("j_done", 32'(bus.state), 32'd0);

    // R-type with unsupported funct
    bus.opcode = 6'b000000;
    bus.funct = 6'b000001;
    cyc();
    chk("badfn_id", 32'(bus.state), 32'd1);
    chk("badfn_illegal", 32'(bus.illegal_op), 32'd1);
    cyc();
    chk("badfn_if", 32'(bus.state), 32'd0);
    chk("badfn_pulse_end", 32'(bus.illegal_op), 32'd0);

    // jal
    bus.opcode = 6'b000011;
    cyc();
`ifdef MC_CTRL_JAL_EN
    chk("jal_id_legal", 32'(bus.illegal_op), 32'd0);
    cyc();
    chk("jal_state", 32'(bus.state), 32'd12);
    chk("jal_reg_dst", 32'(bus.reg_dst), 32'd2);
    chk("jal_mem_to_reg", 32'(bus.mem_to_reg), 32'd2);
    chk("jal_pc_write", 32'(bus.pc_write), 32'd1);
    chk("jal_reg_write", 32'(bus.reg_write), 32'd1);
    cyc();
    chk("jal_done", 32'(bus.state), 32'd0);
`else
    chk("jal_illegal", 32'(bus.illegal_op), 32'd1);
    cyc();
    chk("jal_to_if", 32'(bus.state), 32'd0);
`endif

    // sw aborted by reset while in MWR
    bus.opcode = 6'b101011;
    cyc();
    cyc();
    cyc();
    chk("sw_mwr", 32'(bus.state), 32'd5);
    chk("mwr_mem_write", 32'(bus.mem_write), 32'd1);
    chk("mwr_i_or_d", 32'(bus.i_or_d), 32'd1);
    bus.mem_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("abort_mem_write", 32'(bus.mem_write), 32'd0);
    cyc();
    chk("abort_state", 32'(bus.state), 32'd0);
    chk("abort_mem_write2", 32'(bus.mem_write), 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_if", 32'(bus.state), 32'd0);
    chk("abort_if_read", 32'(bus.mem_read), 32'd1);
    chk("abort_if_write", 32'(bus.mem_write), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
